// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the shared memory port.
// master is the arbiter's view; slave is the view of the pipeline/memory around it.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned XLEN   = 32
);
   // Fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [XLEN-1:0]   if_instr;
   // Data requester
   logic              d_req;
   logic              d_we;
   logic [2:0]        d_funct;
   logic [ADDR_W-1:0] d_addr;
   logic [XLEN-1:0]   d_wdata;
   logic              d_ready;
   logic [XLEN-1:0]   d_rdata;
   logic              d_err;
   // Pipeline control
   logic              stall_if;
   logic              stall_mem;
   // Memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_funct, d_addr, d_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output if_ready, if_instr, d_ready, d_rdata, d_err, stall_if, stall_mem,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_funct, d_addr, d_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  if_ready, if_instr, d_ready, d_rdata, d_err, stall_if, stall_mem,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and the MEM stage.
// One outstanding req/gnt/rvalid transaction; data wins ties because it is the older
// instruction. Also steers store lanes, extends loads and flags misaligned/illegal accesses.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned XLEN   = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   mem_port_arbiter_if.master io_bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
   typedef enum logic {OwnIf, OwnD} owner_e;

   // Load/store funct codes (store codes share B/H/W with loads)
   localparam logic [2:0] FnB  = 3'b000;
   localparam logic [2:0] FnH  = 3'b001;
   localparam logic [2:0] FnW  = 3'b010;
   localparam logic [2:0] FnBu = 3'b011;
   localparam logic [2:0] FnHu = 3'b100;

   localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

   state_e            r_state,     w_state_nxt;
   owner_e            r_owner,     w_owner_nxt;
   logic              r_store,     w_store_nxt;
   logic [2:0]        r_funct,     w_funct_nxt;
   logic [1:0]        r_off,       w_off_nxt;
   logic              r_mem_req,   w_mem_req_nxt;
   logic              r_mem_we,    w_mem_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [3:0]        r_mem_be,    w_mem_be_nxt;
   logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic              r_if_ready,  w_if_ready_nxt;
   logic [XLEN-1:0]   r_if_instr,  w_if_instr_nxt;
   logic              r_d_ready,   w_d_ready_nxt;
   logic [XLEN-1:0]   r_d_rdata,   w_d_rdata_nxt;
   logic              r_d_err,     w_d_err_nxt;

   logic              w_d_err;
   logic [3:0]        w_st_be;
   logic [XLEN-1:0]   w_st_wdata;
   logic [7:0]        w_ld_byte;
   logic [15:0]       w_ld_half;
   logic [XLEN-1:0]   w_ld_data;

   // Decode the pending data request: store lane steering and legality of funct/alignment.
   always_comb begin
      w_d_err    = 1'b0;
      w_st_be    = 4'b0000;
      w_st_wdata = '0;
      if (io_bus.d_we) begin
         case (io_bus.d_funct)
            FnB: begin
               w_st_be    = 4'b0001 << io_bus.d_addr[1:0];
               w_st_wdata = {4{io_bus.d_wdata[7:0]}};
            end
            FnH: begin
               w_st_be    = 4'b0011 << {io_bus.d_addr[1], 1'b0};
               w_st_wdata = {2{io_bus.d_wdata[15:0]}};
               w_d_err    = io_bus.d_addr[0];
            end
            FnW: begin
               w_st_be    = 4'b1111;
               w_st_wdata = io_bus.d_wdata;
               w_d_err    = |io_bus.d_addr[1:0];
            end
            default: w_d_err = 1'b1;
         endcase
      end else begin
         case (io_bus.d_funct)
            FnB, FnBu: w_d_err = 1'b0;
            FnH, FnHu: w_d_err = io_bus.d_addr[0];
            FnW:       w_d_err = |io_bus.d_addr[1:0];
            default:   w_d_err = 1'b1;
         endcase
      end
   end

   // Select the addressed lane of the returned word and sign/zero extend it.
   always_comb begin
      w_ld_byte = io_bus.mem_rdata[7:0];
      case (r_off)
         2'd1:    w_ld_byte = io_bus.mem_rdata[15:8];
         2'd2:    w_ld_byte = io_bus.mem_rdata[23:16];
         2'd3:    w_ld_byte = io_bus.mem_rdata[31:24];
         default: w_ld_byte = io_bus.mem_rdata[7:0];
      endcase
      w_ld_half = r_off[1] ? io_bus.mem_rdata[31:16] : io_bus.mem_rdata[15:0];
      case (r_funct)
         FnB:     w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         FnBu:    w_ld_data = {24'h000000, w_ld_byte};
         FnH:     w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         FnHu:    w_ld_data = {16'h0000, w_ld_half};
         default: w_ld_data = io_bus.mem_rdata;
      endcase
   end

   // Next-state and registered-output logic of the arbitration FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_store_nxt     = r_store;
      w_funct_nxt     = r_funct;
      w_off_nxt       = r_off;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_be_nxt    = r_mem_be;
      w_mem_wdata_nxt = r_mem_wdata;
      w_if_ready_nxt  = 1'b0;
      w_if_instr_nxt  = r_if_instr;
      w_d_ready_nxt   = 1'b0;
      w_d_rdata_nxt   = r_d_rdata;
      w_d_err_nxt     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (io_bus.d_req) begin
               w_owner_nxt = OwnD;
               if (w_d_err) begin
                  // Illegal access completes without touching memory
                  w_state_nxt   = StResp;
                  w_d_ready_nxt = 1'b1;
                  w_d_err_nxt   = 1'b1;
                  w_d_rdata_nxt = '0;
               end else begin
                  w_state_nxt     = StIssue;
                  w_store_nxt     = io_bus.d_we;
                  w_funct_nxt     = io_bus.d_funct;
                  w_off_nxt       = io_bus.d_addr[1:0];
                  w_mem_req_nxt   = 1'b1;
                  w_mem_we_nxt    = io_bus.d_we;
                  w_mem_addr_nxt  = io_bus.d_addr & WordMask;
                  w_mem_be_nxt    = io_bus.d_we ? w_st_be : 4'b1111;
                  w_mem_wdata_nxt = io_bus.d_we ? w_st_wdata : '0;
               end
            end else if (io_bus.if_req) begin
               w_owner_nxt     = OwnIf;
               w_state_nxt     = StIssue;
               w_store_nxt     = 1'b0;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = io_bus.if_addr & WordMask;
               w_mem_be_nxt    = 4'b1111;
               w_mem_wdata_nxt = '0;
            end
         end
         StIssue: begin
            if (io_bus.mem_gnt) begin
               w_state_nxt   = StWait;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
            end
         end
         StWait: begin
            if (io_bus.mem_rvalid) begin
               w_state_nxt = StResp;
               if (r_owner == OwnIf) begin
                  w_if_ready_nxt = 1'b1;
                  w_if_instr_nxt = io_bus.mem_rdata;
               end else begin
                  w_d_ready_nxt = 1'b1;
                  if (!r_store) begin
                     w_d_rdata_nxt = w_ld_data;
                  end
               end
            end
         end
         StResp: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_owner     <= OwnIf;
         r_store     <= 1'b0;
         r_funct     <= 3'b000;
         r_off       <= 2'b00;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= '0;
         r_if_ready  <= 1'b0;
         r_if_instr  <= '0;
         r_d_ready   <= 1'b0;
         r_d_rdata   <= '0;
         r_d_err     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_store     <= w_store_nxt;
         r_funct     <= w_funct_nxt;
         r_off       <= w_off_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_be    <= w_mem_be_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_if_ready  <= w_if_ready_nxt;
         r_if_instr  <= w_if_instr_nxt;
         r_d_ready   <= w_d_ready_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_d_err     <= w_d_err_nxt;
      end
   end

   assign io_bus.mem_req   = r_mem_req;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_be    = r_mem_be;
   assign io_bus.mem_wdata = r_mem_wdata;
   assign io_bus.if_ready  = r_if_ready;
   assign io_bus.if_instr  = r_if_instr;
   assign io_bus.d_ready   = r_d_ready;
   assign io_bus.d_rdata   = r_d_rdata;
   assign io_bus.d_err     = r_d_err;
   assign io_bus.stall_if  = io_bus.if_req && !r_if_ready;
   assign io_bus.stall_mem = io_bus.d_req && !r_d_ready;

endmodule
